// File: rtl/rvfi_pkg.sv
// Shared types and constants for the RVFI retirement tracker.
package rvfi_pkg;

  localparam int RVFI_XLEN    = 32;
  localparam int RVFI_ORDER_W = 64;

  localparam logic [1:0] RVFI_MODE_M = 2'd3;
  localparam logic [1:0] RVFI_IXL_32 = 2'd1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tracker_state_t;

  // One complete RVFI retirement record, as presented on the RVFI ports.
  typedef struct packed {
    logic [RVFI_ORDER_W-1:0] order;
    logic [31:0]             insn;
    logic                    trap;
    logic                    halt;
    logic                    intr;
    logic [1:0]              mode;
    logic [1:0]              ixl;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [4:0]              rd_addr;
    logic [RVFI_XLEN-1:0]    rs1_rdata;
    logic [RVFI_XLEN-1:0]    rs2_rdata;
    logic [RVFI_XLEN-1:0]    rd_wdata;
    logic [RVFI_XLEN-1:0]    pc_rdata;
    logic [RVFI_XLEN-1:0]    pc_wdata;
    logic [RVFI_XLEN-1:0]    mem_addr;
    logic [RVFI_XLEN/8-1:0]  mem_rmask;
    logic [RVFI_XLEN/8-1:0]  mem_wmask;
    logic [RVFI_XLEN-1:0]    mem_rdata;
    logic [RVFI_XLEN-1:0]    mem_wdata;
  } rvfi_record_t;

  // Record value seen on the ports out of reset: all zero apart from the
  // fixed privilege mode and XLEN encoding.
  function automatic rvfi_record_t rvfi_reset_record();
    rvfi_record_t r;
    r      = '0;
    r.mode = RVFI_MODE_M;
    r.ixl  = RVFI_IXL_32;
    return r;
  endfunction

endpackage

// File: rtl/rvfi_retire_tracker.sv
// Collects the side effects of one multi-cycle instruction (fetch, operand
// read, memory access, writeback) and emits a single registered RVFI
// retirement record per instruction with a monotonically increasing order.
//
// Strobe semantics: there is no backpressure. Every *_fire / retire input is
// a single-cycle event sampled on the rising clock edge and is always
// accepted; rvfi_valid is a one-cycle strobe and the record fields hold
// their value until the next strobe.
module rvfi_retire_tracker
  import rvfi_pkg::*;
#(
  parameter int XLEN    = RVFI_XLEN,
  parameter int ORDER_W = RVFI_ORDER_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_fire,
  input  logic [31:0]         fetch_insn,
  input  logic [XLEN-1:0]     fetch_pc,
  input  logic                rs_fire,
  input  logic [4:0]          rs1_addr,
  input  logic [4:0]          rs2_addr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic                mem_fire,
  input  logic [XLEN-1:0]     mem_addr_i,
  input  logic [XLEN/8-1:0]   mem_rmask_i,
  input  logic [XLEN/8-1:0]   mem_wmask_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  input  logic [XLEN-1:0]     mem_wdata_i,
  input  logic                wb_fire,
  input  logic [4:0]          wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                retire,
  input  logic                retire_trap,
  input  logic [XLEN-1:0]     retire_next_pc,
  output logic                rvfi_valid,
  output logic [ORDER_W-1:0]  rvfi_order,
  output logic [31:0]         rvfi_insn,
  output logic                rvfi_trap,
  output logic                rvfi_halt,
  output logic                rvfi_intr,
  output logic [1:0]          rvfi_mode,
  output logic [1:0]          rvfi_ixl,
  output logic [4:0]          rvfi_rs1_addr,
  output logic [4:0]          rvfi_rs2_addr,
  output logic [4:0]          rvfi_rd_addr,
  output logic [XLEN-1:0]     rvfi_rs1_rdata,
  output logic [XLEN-1:0]     rvfi_rs2_rdata,
  output logic [XLEN-1:0]     rvfi_rd_wdata,
  output logic [XLEN-1:0]     rvfi_pc_rdata,
  output logic [XLEN-1:0]     rvfi_pc_wdata,
  output logic [XLEN-1:0]     rvfi_mem_addr,
  output logic [XLEN-1:0]     rvfi_mem_rdata,
  output logic [XLEN-1:0]     rvfi_mem_wdata,
  output logic [XLEN/8-1:0]   rvfi_mem_rmask,
  output logic [XLEN/8-1:0]   rvfi_mem_wmask
);

  tracker_state_t state_q, state_d;

  logic               protocol_err_q;
  logic               halted_q;
  logic [ORDER_W-1:0] count_q;

  // Control decoded from the FSM each cycle.
  logic record_fire;   // register a record this cycle
  logic err_set;       // protocol violation observed this cycle
  logic capture_ops;   // operand/memory/writeback strobes belong to an instruction

  // Per-instruction capture registers. A field never captured stays zero,
  // which is exactly what the record must show for it.
  logic [31:0]       insn_q;
  logic [XLEN-1:0]   pc_q;
  logic [4:0]        rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, rd_data_q;
  logic [XLEN-1:0]   mem_addr_q, mem_rdata_q, mem_wdata_q;
  logic [XLEN/8-1:0] mem_rmask_q, mem_wmask_q;

  rvfi_record_t rec_d, rec_q;
  logic         valid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control decode.
  always_comb begin
    state_d     = state_q;
    record_fire = 1'b0;
    err_set     = 1'b0;
    capture_ops = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_fire) state_d = BUSY;
        if (retire)     err_set = 1'b1;
      end
      BUSY: begin
        capture_ops = 1'b1;
        if (retire) begin
          // Once halted the checker expects silence, so retirements vanish.
          record_fire = !halted_q;
          if (!fetch_fire) state_d = IDLE;
        end else if (fetch_fire) begin
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Assemble the record from captured fields, letting same-cycle strobes win.
  always_comb begin
    rec_d           = rvfi_reset_record();
    rec_d.order     = count_q;
    rec_d.insn      = insn_q;
    rec_d.trap      = retire_trap | protocol_err_q;
    rec_d.halt      = retire_trap | protocol_err_q;
    rec_d.pc_rdata  = pc_q;
    rec_d.pc_wdata  = retire_next_pc;
    rec_d.rs1_addr  = rs_fire  ? rs1_addr    : rs1_addr_q;
    rec_d.rs2_addr  = rs_fire  ? rs2_addr    : rs2_addr_q;
    rec_d.rs1_rdata = rs_fire  ? rs1_data    : rs1_data_q;
    rec_d.rs2_rdata = rs_fire  ? rs2_data    : rs2_data_q;
    rec_d.mem_addr  = mem_fire ? mem_addr_i  : mem_addr_q;
    rec_d.mem_rmask = mem_fire ? mem_rmask_i : mem_rmask_q;
    rec_d.mem_wmask = mem_fire ? mem_wmask_i : mem_wmask_q;
    rec_d.mem_rdata = mem_fire ? mem_rdata_i : mem_rdata_q;
    rec_d.mem_wdata = mem_fire ? mem_wdata_i : mem_wdata_q;
    rec_d.rd_addr   = wb_fire  ? wb_addr     : rd_addr_q;
    rec_d.rd_wdata  = wb_fire  ? wb_data     : rd_data_q;
    // x0 is hardwired to zero regardless of what the core tried to write.
    if (rec_d.rd_addr == 5'd0) rec_d.rd_wdata = '0;
  end

  // Capture registers: a fetch starts a fresh instruction, otherwise the
  // latest strobe of each kind overwrites the previous one.
  always_ff @(posedge clk) begin
    if (reset || fetch_fire) begin
      insn_q      <= reset ? '0 : fetch_insn;
      pc_q        <= reset ? '0 : fetch_pc;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_rdata_q <= '0;
      mem_wdata_q <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else if (capture_ops) begin
      if (rs_fire) begin
        rs1_addr_q <= rs1_addr;
        rs2_addr_q <= rs2_addr;
        rs1_data_q <= rs1_data;
        rs2_data_q <= rs2_data;
      end
      if (mem_fire) begin
        mem_addr_q  <= mem_addr_i;
        mem_rmask_q <= mem_rmask_i;
        mem_wmask_q <= mem_wmask_i;
        mem_rdata_q <= mem_rdata_i;
        mem_wdata_q <= mem_wdata_i;
      end
      if (wb_fire) begin
        rd_addr_q <= wb_addr;
        rd_data_q <= wb_data;
      end
    end
  end

  // Output record register and one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rec_q   <= rvfi_reset_record();
    end else begin
      valid_q <= record_fire;
      if (record_fire) rec_q <= rec_d;
    end
  end

  // Retirement counter, sticky halt and protocol error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      halted_q       <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (record_fire) count_q <= count_q + 1'b1;
      if (record_fire && rec_d.trap) halted_q <= 1'b1;
      // An error is reported by exactly one record, then forgotten.
      if (record_fire)  protocol_err_q <= 1'b0;
      else if (err_set) protocol_err_q <= 1'b1;
    end
  end

  assign rvfi_valid     = valid_q;
  assign rvfi_order     = rec_q.order;
  assign rvfi_insn      = rec_q.insn;
  assign rvfi_trap      = rec_q.trap;
  assign rvfi_halt      = rec_q.halt;
  assign rvfi_intr      = rec_q.intr;
  assign rvfi_mode      = rec_q.mode;
  assign rvfi_ixl       = rec_q.ixl;
  assign rvfi_rs1_addr  = rec_q.rs1_addr;
  assign rvfi_rs2_addr  = rec_q.rs2_addr;
  assign rvfi_rd_addr   = rec_q.rd_addr;
  assign rvfi_rs1_rdata = rec_q.rs1_rdata;
  assign rvfi_rs2_rdata = rec_q.rs2_rdata;
  assign rvfi_rd_wdata  = rec_q.rd_wdata;
  assign rvfi_pc_rdata  = rec_q.pc_rdata;
  assign rvfi_pc_wdata  = rec_q.pc_wdata;
  assign rvfi_mem_addr  = rec_q.mem_addr;
  assign rvfi_mem_rdata = rec_q.mem_rdata;
  assign rvfi_mem_wdata = rec_q.mem_wdata;
  assign rvfi_mem_rmask = rec_q.mem_rmask;
  assign rvfi_mem_wmask = rec_q.mem_wmask;

endmodule
